wb_traffic_gen: RTL and testbench

WB_TRAFFIC_GEN -- requirements
Module: wb_traffic_gen

---
 rtl/wb_tgen_pkg.sv | 27 ++
 rtl/wb_tgen_pattern.sv | 56 +++++
 rtl/wb_traffic_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_wb_traffic_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_tgen_pkg.sv
// Shared types and constants for the Wishbone traffic generator.
// Holds the FSM state enum, Wishbone CTI codes and the LFSR tap table (used with WB_TGEN_LFSR_EN).
package wb_tgen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    GAP,
    RD,
    NEXT,
    DONE
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Right-shifting Galois masks for maximal-length polynomials, indexed by data width.
  function automatic logic [31:0] lfsr_taps(input int dw);
    case (dw)
      8:       return 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
      16:      return 32'h0000_B400;  // x^16+x^14+x^13+x^11+1
      default: return 32'h8020_0003;  // x^32+x^22+x^2+x+1
    endcase
  endfunction

endpackage

// File: rtl/wb_tgen_pattern.sv
// Data pattern source: incrementing word by default, Galois LFSR when WB_TGEN_LFSR_EN is defined.
// A snapshot register lets the read phase regenerate the words of the burst just written.
module wb_tgen_pattern
  import wb_tgen_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          load_i,
  input  logic [DW-1:0] seed_i,
  input  logic          step_i,
  input  logic          save_i,
  input  logic          restore_i,
  output logic [DW-1:0] word_o
);

  logic [DW-1:0] word_q, word_d;
  logic [DW-1:0] snap_q, snap_d;
  logic [DW-1:0] seed_word;
  logic [DW-1:0] next_word;

`ifdef WB_TGEN_LFSR_EN
  localparam logic [31:0]   TAPS_ALL = lfsr_taps(DW);
  localparam logic [DW-1:0] TAPS     = TAPS_ALL[DW-1:0];

  // An all-zero LFSR state would lock up, so a zero seed starts from 1.
  assign seed_word = (seed_i == '0) ? DW'(1) : seed_i;
  assign next_word = (word_q >> 1) ^ (word_q[0] ? TAPS : '0);
`else
  assign seed_word = seed_i;
  assign next_word = word_q + DW'(1);
`endif

  always_comb begin
    word_d = word_q;
    snap_d = snap_q;
    if (save_i) snap_d = word_q;
    if (load_i)         word_d = seed_word;
    else if (restore_i) word_d = snap_q;
    else if (step_i)    word_d = next_word;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      word_q <= '0;
      snap_q <= '0;
    end else begin
      word_q <= word_d;
      snap_q <= snap_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/wb_traffic_gen.sv
// Wishbone B4 burst traffic generator: writes a burst, reads it back and checks it, repeated per run.
// Pattern selection via WB_TGEN_LFSR_EN (see wb_tgen_pattern); default is an incrementing word.
module wb_traffic_gen
  import wb_tgen_pkg::*;
#(
  parameter int APP_AW    = 26,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [APP_AW-1:0] base_addr_i,
  input  logic [7:0]        burst_len_i,
  input  logic [15:0]       num_bursts_i,
  input  logic [DW-1:0]     seed_i,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [15:0]       err_cnt_o,
  output logic [APP_AW-1:0] err_addr_o
);

  localparam int BYTES = DW / 8;
  localparam int LEN_W = $clog2(MAX_BURST + 1);

  state_e            state_q, state_d;
  logic [APP_AW-1:0] base_q, base_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [15:0]       rem_q, rem_d;
  logic              err_q, err_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [APP_AW-1:0] err_addr_q, err_addr_d;

  logic              pat_load, pat_step, pat_save, pat_restore;
  logic [DW-1:0]     pat_word;
  logic [LEN_W-1:0]  len_clamped;
  logic              last_beat;
  logic [APP_AW-1:0] stride;

  always_comb begin
    if (burst_len_i == 8'd0)                len_clamped = LEN_W'(1);
    else if (int'(burst_len_i) > MAX_BURST) len_clamped = LEN_W'(MAX_BURST);
    else                                    len_clamped = LEN_W'(burst_len_i);
  end

  assign last_beat = (beat_q == len_q - LEN_W'(1));
  assign stride    = APP_AW'(len_q) * APP_AW'(BYTES);

  wb_tgen_pattern #(
    .DW(DW)
  ) u_pattern (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .load_i   (pat_load),
    .seed_i   (seed_i),
    .step_i   (pat_step),
    .save_i   (pat_save),
    .restore_i(pat_restore),
    .word_o   (pat_word)
  );

  // Next-state and control decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    base_d      = base_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    rem_d       = rem_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    err_addr_d  = err_addr_q;
    pat_load    = 1'b0;
    pat_step    = 1'b0;
    pat_save    = 1'b0;
    pat_restore = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          pat_load   = 1'b1;
          base_d     = base_addr_i;
          addr_d     = base_addr_i;
          len_d      = len_clamped;
          beat_d     = '0;
          rem_d      = num_bursts_i;
          err_d      = 1'b0;
          err_cnt_d  = '0;
          err_addr_d = '0;
          state_d    = (num_bursts_i == 16'd0) ? NEXT : WR;
        end
      end

      WR: begin
        // Snapshot the pattern at the first write beat so the readback can replay it.
        pat_save = (beat_q == '0);
        if (wb_ack_i) begin
          pat_step = 1'b1;
          if (last_beat) begin
            beat_d  = '0;
            addr_d  = base_q;
            state_d = GAP;
          end else begin
            beat_d = beat_q + LEN_W'(1);
            addr_d = addr_q + APP_AW'(BYTES);
          end
        end
      end

      GAP: begin
        pat_restore = 1'b1;
        state_d     = RD;
      end

      RD: begin
        if (wb_ack_i) begin
          pat_step = 1'b1;
          if (wb_dat_i != pat_word) begin
            err_d = 1'b1;
            if (!err_q) err_addr_d = addr_q;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
          if (last_beat) begin
            beat_d  = '0;
            rem_d   = rem_q - 16'd1;
            state_d = NEXT;
          end else begin
            beat_d = beat_q + LEN_W'(1);
            addr_d = addr_q + APP_AW'(BYTES);
          end
        end
      end

      NEXT: begin
        if (rem_q == 16'd0) begin
          state_d = DONE;
        end else begin
          base_d  = base_q + stride;
          addr_d  = base_q + stride;
          state_d = WR;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Bus and status outputs decode straight from registered state.
  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_dat_o = '0;
    wb_sel_o = '0;
    wb_cti_o = CTI_CLASSIC;
    busy_o   = 1'b0;
    done_o   = 1'b0;

    if (state_q == WR || state_q == RD) begin
      wb_cyc_o = 1'b1;
      wb_stb_o = 1'b1;
      wb_sel_o = '1;
      if (len_q == LEN_W'(1)) wb_cti_o = CTI_CLASSIC;
      else if (last_beat)     wb_cti_o = CTI_EOB;
      else                    wb_cti_o = CTI_INCR;
    end
    if (state_q == WR) begin
      wb_we_o  = 1'b1;
      wb_dat_o = pat_word;
    end
    busy_o = (state_q == WR) || (state_q == GAP) || (state_q == RD) || (state_q == NEXT);
    done_o = (state_q == DONE);
  end

  assign wb_addr_o  = addr_q;
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;
  assign err_addr_o = err_addr_q;

  always_ff @(posedge wb_clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    if (wb_rst_i) begin
      state_q    <= IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_wb_traffic_gen.sv
// Self-checking bench for wb_traffic_gen: memory slave with wait states and read corruption,
// transaction monitor, and a run-level reference model of the expected bus beats and errors.
module tb_wb_traffic_gen;

  localparam int APP_AW    = 26;
  localparam int DW        = 32;
  localparam int MAX_BURST = 16;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [APP_AW-1:0] base_addr_i = '0;
  logic [7:0]        burst_len_i = '0;
  logic [15:0]       num_bursts_i = '0;
  logic [DW-1:0]     seed_i = '0;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [APP_AW-1:0] wb_addr_o;
  logic [DW-1:0]     wb_dat_o;
  logic [DW/8-1:0]   wb_sel_o;
  logic [2:0]        wb_cti_o;
  logic              wb_ack_i;
  logic [DW-1:0]     wb_dat_i;
  logic              busy_o, done_o, err_o;
  logic [15:0]       err_cnt_o;
  logic [APP_AW-1:0] err_addr_o;

  wb_traffic_gen #(
    .APP_AW(APP_AW), .DW(DW), .MAX_BURST(MAX_BURST)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .burst_len_i(burst_len_i), .num_bursts_i(num_bursts_i),
    .seed_i(seed_i), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory slave: ack after a programmable number of wait states, optional read corruption.
  int                wait_states = 0;
  int                wait_cnt = 0;
  logic              corrupt_en = 1'b0;
  logic [APP_AW-1:0] corrupt_addr = '0;
  logic [DW-1:0]     mem [256];
  logic [DW-1:0]     rd_word;

  assign wb_ack_i = wb_cyc_o && wb_stb_o && (wait_cnt == wait_states);
  assign rd_word  = mem[wb_addr_o[9:2]];
  assign wb_dat_i = (corrupt_en && wb_addr_o == corrupt_addr) ? (rd_word ^ 32'h1) : rd_word;

  always @(posedge wb_clk_i) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (wb_ack_i && wb_we_o) mem[wb_addr_o[9:2]] <= wb_dat_o;
  end

  // Monitor, sampled on the falling edge.
  logic [79:0] obs_q[$];
  int          cyc_cycles = 0;
  int          idle_busy = 0;
  int          done_cnt = 0;
  int          unstable = 0;
  logic        prev_pending = 1'b0;
  logic [65:0] prev_sig = '0;

  always @(negedge wb_clk_i) begin
    if (wb_cyc_o) cyc_cycles <= cyc_cycles + 1;
    if (busy_o && !wb_cyc_o) idle_busy <= idle_busy + 1;
    if (done_o) done_cnt <= done_cnt + 1;
    if (wb_stb_o && prev_pending && ({wb_sel_o, wb_we_o, wb_cti_o, wb_addr_o, wb_dat_o} != prev_sig))
      unstable <= unstable + 1;
    prev_pending <= wb_stb_o && !wb_ack_i;
    prev_sig     <= {wb_sel_o, wb_we_o, wb_cti_o, wb_addr_o, wb_dat_o};
    if (wb_cyc_o && wb_stb_o && wb_ack_i)
      obs_q.push_back({14'd0, wb_sel_o, wb_we_o, wb_cti_o, wb_addr_o, (wb_we_o ? wb_dat_o : 32'h0)});
  end

  // Reference pattern: word n of the run.
  function automatic logic [31:0] pat(input logic [31:0] seed, input int n);
`ifdef WB_TGEN_LFSR_EN
    logic [31:0] s;
    s = (seed == 32'h0) ? 32'h1 : seed;
    for (int k = 0; k < n; k++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
`else
    return seed + 32'(n);
`endif
  endfunction

  task automatic clear_mon();
    obs_q.delete();
    cyc_cycles = 0;
    idle_busy  = 0;
    done_cnt   = 0;
    unstable   = 0;
  endtask

  task automatic run_case(input string tag, input logic [APP_AW-1:0] base, input logic [7:0] len,
                          input logic [15:0] nb, input logic [31:0] seed, input int waits,
                          input logic cor, input logic [APP_AW-1:0] caddr, input logic poke);
    logic [79:0]       exp_q[$];
    int                eff_len, exp_err, n;
    logic [APP_AW-1:0] exp_eaddr, a;
    logic [2:0]        cti;
    logic              seen;

    wait_states  = waits;
    corrupt_en   = cor;
    corrupt_addr = caddr;
    @(posedge wb_clk_i); #1;
    clear_mon();
    base_addr_i  = base;
    burst_len_i  = len;
    num_bursts_i = nb;
    seed_i       = seed;
    start_i      = 1'b1;
    seen         = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(posedge wb_clk_i); #1;
      start_i = poke && (c == 6);
      if (start_i) begin
        base_addr_i = 26'h3000;
        burst_len_i = 8'd1;
        seed_i      = 32'hDEAD_BEEF;
      end
      if (done_o) seen = 1'b1;
    end
    start_i = 1'b0;
    check({tag, " done_seen"}, 80'(seen), 80'(1));
    @(posedge wb_clk_i); #1;
    check({tag, " done_busy_after"}, {78'd0, done_o, busy_o}, 80'd0);
    @(posedge wb_clk_i); #1;

    // Expected beat list from the run rules.
    eff_len   = (len == 8'd0) ? 1 : ((int'(len) > MAX_BURST) ? MAX_BURST : int'(len));
    exp_err   = 0;
    exp_eaddr = '0;
    for (int b = 0; b < int'(nb); b++)
      for (int ph = 0; ph < 2; ph++)
        for (int i = 0; i < eff_len; i++) begin
          n   = b * eff_len + i;
          a   = base + APP_AW'(n * 4);
          cti = (eff_len == 1) ? 3'b000 : ((i == eff_len - 1) ? 3'b111 : 3'b010);
          exp_q.push_back({14'd0, 4'hF, (ph == 0), cti, a, ((ph == 0) ? pat(seed, n) : 32'h0)});
          if (ph == 1 && cor && a == caddr) begin
            if (exp_err == 0) exp_eaddr = a;
            exp_err++;
          end
        end

    check({tag, " beat_count"}, 80'(obs_q.size()), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check($sformatf("%s beat%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, " cyc_cycles"}, 80'(cyc_cycles), 80'(exp_q.size() * (waits + 1)));
    check({tag, " idle_busy_cycles"}, 80'(idle_busy), 80'(2 * int'(nb)));
    check({tag, " stable_while_waiting"}, 80'(unstable), 80'd0);
    check({tag, " done_pulses"}, 80'(done_cnt), 80'd1);
    check({tag, " err_o"}, 80'(err_o), 80'(exp_err > 0));
    check({tag, " err_cnt"}, 80'(err_cnt_o), 80'(exp_err));
    check({tag, " err_addr"}, 80'(err_addr_o), 80'(exp_eaddr));
    corrupt_en = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        found;
    int          cyc_snap;

    // Reset state.
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("reset strobes", {77'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 80'd0);
    check("reset addr_dat", {22'd0, wb_addr_o, wb_dat_o}, 80'd0);
    check("reset sel_cti", {73'd0, wb_sel_o, wb_cti_o}, 80'd0);
    check("reset status", {78'd0, busy_o, done_o}, 80'd0);
    check("reset errors", {37'd0, err_o, err_cnt_o, err_addr_o}, 80'd0);
    wb_rst_i = 1'b0;

    run_case("zero_wait", 26'h100, 8'd4, 16'd2, 32'h0, 0, 1'b0, '0, 1'b1);
    run_case("wait3", 26'h100, 8'd4, 16'd2, 32'h0, 3, 1'b0, '0, 1'b0);
    run_case("corrupt", 26'h100, 8'd4, 16'd2, 32'h0, 0, 1'b1, 26'h108, 1'b0);
    run_case("after_corrupt", 26'h100, 8'd4, 16'd1, 32'h0, 0, 1'b0, '0, 1'b0);
    run_case("len1", 26'h40, 8'd1, 16'd3, 32'hFFFF_FFFE, 0, 1'b0, '0, 1'b0);
    run_case("len0", 26'h80, 8'd0, 16'd2, 32'h1234_5678, 1, 1'b0, '0, 1'b0);
    run_case("clamp", 26'h200, 8'd200, 16'd1, 32'h0000_00A0, 1, 1'b0, '0, 1'b0);
    run_case("wrap", 26'h3FF_FFF8, 8'd4, 16'd1, 32'h0000_0010, 0, 1'b0, '0, 1'b0);

    // Zero bursts: no bus activity, done two cycles after start.
    @(posedge wb_clk_i); #1;
    clear_mon();
    base_addr_i  = 26'h100;
    burst_len_i  = 8'd4;
    num_bursts_i = 16'd0;
    start_i      = 1'b1;
    @(posedge wb_clk_i); #1;
    start_i = 1'b0;
    check("nb0 done_early", 80'(done_o), 80'd0);
    @(posedge wb_clk_i); #1;
    check("nb0 done_at_2", 80'(done_o), 80'd1);
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("nb0 no_cyc", 80'(cyc_cycles), 80'd0);
    check("nb0 done_pulses", 80'(done_cnt), 80'd1);

    // Reset during beat 2 of a write burst.
    wait_states = 3;
    @(posedge wb_clk_i); #1;
    clear_mon();
    base_addr_i  = 26'h200;
    burst_len_i  = 8'd4;
    num_bursts_i = 16'd1;
    seed_i       = 32'h5;
    start_i      = 1'b1;
    @(posedge wb_clk_i); #1;
    start_i = 1'b0;
    found   = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge wb_clk_i);
      if (wb_cyc_o && wb_we_o && wb_addr_o == 26'h208) found = 1'b1;
    end
    check("midrst reached_beat2", 80'(found), 80'd1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("midrst bus_idle", {77'd0, wb_cyc_o, wb_stb_o, busy_o}, 80'd0);
    wb_rst_i = 1'b0;
    cyc_snap = cyc_cycles;
    repeat (10) @(posedge wb_clk_i);
    #1;
    check("midrst beats_before", 80'(obs_q.size()), 80'd2);
    check("midrst no_more_cyc", 80'(cyc_cycles), 80'(cyc_snap));
    run_case("after_reset", 26'h200, 8'd4, 16'd1, 32'h5, 2, 1'b0, '0, 1'b0);

    // Randomised runs.
    for (int k = 0; k < 4; k++) begin
      r = $urandom;
      run_case($sformatf("rand%0d", k), r[25:0] & 26'h3FF_FFFC, 8'($urandom_range(0, 20)),
               16'($urandom_range(1, 3)), $urandom, $urandom_range(0, 2), 1'b0, '0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
